// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: turns raw clock/data pins into toggling 11-bit key events.
// Handles the E0/F0 prefixes, skips the E1 Pause sequence, and flags parity, stop and timeout errors.
module ps2_scan_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 48000
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt;
  logic          clk_filt_d;
  logic          fall;
  logic          data_s;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext;
  logic          rel;
  logic [2:0]    skip;
  logic          byte_ok;
  logic          is_noise;

  assign data_s  = data_sync[1];
  assign fall    = clk_filt_d & ~clk_filt;
  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign byte_ok = data_s & (^{shreg, par_bit});
  assign is_noise = (shreg == 8'hFA) || (shreg == 8'hAA) || (shreg == 8'hEE) ||
                    (shreg == 8'hFE) || (shreg == 8'h00) || (shreg == 8'hFF);

  always_ff @(posedge clk_24 or negedge reset) begin
    if (!reset) begin
      clk_sync   <= 2'b00;
      data_sync  <= 2'b00;
      filt_cnt   <= '0;
      clk_filt   <= 1'b0;
      clk_filt_d <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_24 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      ext        <= 1'b0;
      rel        <= 1'b0;
      skip       <= 3'd0;
      ps2_key    <= 11'h000;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      // A stalled frame is abandoned, but prefixes already seen stay armed.
      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) begin
        state     <= IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!byte_ok) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              rel       <= 1'b0;
              skip      <= 3'd0;
            end else if (skip != 3'd0) begin
              skip <= skip - 3'd1;
            end else if (shreg == 8'hE1) begin
              skip <= 3'd7;
            end else if (shreg == 8'hE0) begin
              ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
              rel <= 1'b1;
            end else if (!(is_noise && !ext && !rel)) begin
              ps2_key    <= {~ps2_key[10], ~rel, ext, shreg};
              key_strobe <= 1'b1;
              ext        <= 1'b0;
              rel        <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: expected key events queued as frames are sent, checked on each strobe.
module tb_ps2_scan_rx;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  int compared   = 0;
  int mismatched = 0;
  int err_seen   = 0;
  logic [10:0] exp_q[$];

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT(400)) dut (
    .clk_24     (clk_24),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk_24 = ~clk_24;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued event.
  always @(negedge clk_24) begin
    if (reset === 1'b1) begin
      if (frame_err) err_seen++;
      if (key_strobe) begin
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("ps2_key", 32'(ps2_key), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input int nbits = 11);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (20) @(posedge clk_24);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk_24);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (40) @(posedge clk_24);
  endtask

  task automatic settle(input string tag, input int exp_err);
    repeat (30) @(posedge clk_24);
    @(negedge clk_24);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_errors"}, 32'(err_seen), 32'(exp_err));
  endtask

  initial begin
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk_24);
    @(negedge clk_24);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_strobe", 32'(key_strobe), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clk_24);

    exp_q.push_back(11'h61C);
    send_frame(8'h1C);
    settle("make_1c", 0);

    exp_q.push_back(11'h01C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    settle("break_1c", 0);

    exp_q.push_back(11'h775);
    send_frame(8'hE0);
    send_frame(8'h75);
    settle("ext_make", 0);

    exp_q.push_back(11'h175);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    settle("ext_break", 0);

    send_frame(8'h1C, 1'b1);
    settle("parity_err", 1);
    check("key_after_parity_err", 32'(ps2_key), 32'h175);

    exp_q.push_back(11'h61B);
    send_frame(8'h1B);
    settle("after_err", 1);

    send_frame(8'h29, 1'b0, 5);
    repeat (500) @(posedge clk_24);
    settle("timeout", 2);
    check("key_after_timeout", 32'(ps2_key), 32'h61B);

    exp_q.push_back(11'h229);
    send_frame(8'h29);
    settle("after_timeout", 2);

    send_frame(8'hFA);
    settle("ack_ignored", 2);
    check("key_after_ack", 32'(ps2_key), 32'h229);

    send_frame(8'hE1);
    send_frame(8'h14);
    send_frame(8'h77);
    send_frame(8'hE1);
    send_frame(8'hF0);
    send_frame(8'h14);
    send_frame(8'hF0);
    send_frame(8'h77);
    settle("pause_silent", 2);
    exp_q.push_back(11'h616);
    send_frame(8'h16);
    settle("after_pause", 2);

    send_frame(8'h1C, 1'b0, 4);
    reset = 1'b0;
    repeat (3) @(posedge clk_24);
    @(negedge clk_24);
    check("midframe_reset_key", 32'(ps2_key), 32'h000);
    check("midframe_reset_strobe", 32'(key_strobe), 32'd0);
    check("midframe_reset_err", 32'(frame_err), 32'd0);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    reset    = 1'b1;
    repeat (20) @(posedge clk_24);

    exp_q.push_back(11'h61C);
    send_frame(8'h1C);
    exp_q.push_back(11'h21C);
    send_frame(8'h1C);
    settle("after_reset", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
